// File: rtl/axi_lsu_v2.sv
// Single-beat AXI4 load/store unit: one request at a time, aligned accesses only,
// load data extracted from its byte lane and sign/zero extended, store data lane-shifted.
module axi_lsu_v2 #(
  parameter int         DATA_W = 32,
  parameter logic [3:0] AXI_ID = 4'h1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  // Request side
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_ren,
  input  logic                  i_wen,
  input  logic [31:0]           i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [4:0]            i_rd,
  // Response side
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_W-1:0]     o_rdata,
  output logic [4:0]            o_rd,
  output logic                  o_fault,
  output logic                  o_misalign,
  // AXI4 AR
  output logic [31:0]           o_axi_araddr,
  output logic                  o_axi_arvalid,
  input  logic                  i_axi_arready,
  output logic [3:0]            o_axi_arid,
  output logic [7:0]            o_axi_arlen,
  output logic [2:0]            o_axi_arsize,
  output logic [1:0]            o_axi_arburst,
  // AXI4 R
  input  logic [DATA_W-1:0]     i_axi_rdata,
  input  logic                  i_axi_rvalid,
  input  logic [1:0]            i_axi_rresp,
  input  logic                  i_axi_rlast,
  input  logic [3:0]            i_axi_rid,
  output logic                  o_axi_rready,
  // AXI4 AW/W/B
  output logic [31:0]           o_axi_awaddr,
  output logic                  o_axi_awvalid,
  input  logic                  i_axi_awready,
  output logic [3:0]            o_axi_awid,
  output logic [7:0]            o_axi_awlen,
  output logic [2:0]            o_axi_awsize,
  output logic [1:0]            o_axi_awburst,
  output logic [DATA_W-1:0]     o_axi_wdata,
  output logic [DATA_W/8-1:0]   o_axi_wstrb,
  output logic                  o_axi_wvalid,
  input  logic                  i_axi_wready,
  output logic                  o_axi_wlast,
  input  logic                  i_axi_bvalid,
  input  logic [1:0]            i_axi_bresp,
  input  logic [3:0]            i_axi_bid,
  output logic                  o_axi_bready,
  // Debug: current FSM state
  output logic [2:0]            o_dbg_state
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam int         OFF_W    = (DATA_W == 64) ? 3 : 2;
  localparam logic [1:0] MAX_SIZE = 2'(OFF_W);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, OUT} state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [4:0]          rd_q, rd_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                fault_q, fault_d;
  logic                misalign_q, misalign_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic [OFF_W-1:0]    off;
  logic [2:0]          align_mask;
  logic                req_bad;
  logic [DATA_W-1:0]   shifted, ext_mask, load_ext;
  logic                sign_bit;
  logic [STRB_W-1:0]   strb_base;

  assign off = addr_q[OFF_W-1:0];

  // Lane extraction and extension of the returned read beat.
  always_comb begin
    shifted  = i_axi_rdata >> {off, 3'b000};
    ext_mask = '1;
    sign_bit = shifted[DATA_W-1];
    case (size_q)
      2'd0: begin ext_mask = DATA_W'(8'hFF);         sign_bit = shifted[7];  end
      2'd1: begin ext_mask = DATA_W'(16'hFFFF);      sign_bit = shifted[15]; end
      2'd2: begin ext_mask = DATA_W'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: begin ext_mask = '1;                  sign_bit = shifted[DATA_W-1]; end
    endcase
    load_ext = (shifted & ext_mask) | ((sign_bit && !uns_q) ? ~ext_mask : '0);
  end

  always_comb begin
    align_mask = 3'b000;
    strb_base  = '1;
    case (i_size)
      2'd0: align_mask = 3'b000;
      2'd1: align_mask = 3'b001;
      2'd2: align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    case (size_q)
      2'd0: strb_base = STRB_W'(1);
      2'd1: strb_base = STRB_W'(3);
      2'd2: strb_base = STRB_W'(15);
      default: strb_base = '1;
    endcase
    req_bad = (i_size > MAX_SIZE) || ((i_addr[2:0] & align_mask) != 3'b000);
  end

  // Handshakes: a transfer happens on any rising edge where valid && ready; the
  // sender holds valid and its payload stable until then.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    misalign_d = misalign_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          addr_d     = i_addr;
          wdata_d    = i_wdata;
          size_d     = i_size;
          uns_d      = i_unsigned;
          rd_d       = i_rd;
          rdata_d    = '0;
          fault_d    = 1'b0;
          misalign_d = (i_ren || i_wen) && req_bad;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          if (!(i_ren || i_wen) || req_bad) state_d = OUT;
          else if (i_wen)                   state_d = AW_W;
          else                              state_d = AR;
        end
      end
      AR: if (i_axi_arready) state_d = R;
      R: begin
        if (i_axi_rvalid) begin
          rdata_d = load_ext;
          fault_d = i_axi_rresp[1];
          state_d = OUT;
        end
      end
      AW_W: begin
        // Both channels may complete in the same cycle; the done_d terms cover that.
        aw_done_d = aw_done_q || i_axi_awready;
        w_done_d  = w_done_q || i_axi_wready;
        if (aw_done_d && w_done_d) state_d = B;
      end
      B: begin
        if (i_axi_bvalid) begin
          fault_d = i_axi_bresp[1];
          state_d = OUT;
        end
      end
      OUT: if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
      misalign_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
      misalign_q <= misalign_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  assign o_ready       = (state_q == IDLE);
  assign o_valid       = (state_q == OUT);
  assign o_rdata       = rdata_q;
  assign o_rd          = rd_q;
  assign o_fault       = fault_q;
  assign o_misalign    = misalign_q;

  assign o_axi_araddr  = addr_q;
  assign o_axi_arvalid = (state_q == AR);
  assign o_axi_arid    = AXI_ID;
  assign o_axi_arlen   = 8'd0;
  assign o_axi_arsize  = {1'b0, size_q};
  assign o_axi_arburst = 2'b01;
  assign o_axi_rready  = (state_q == R);

  assign o_axi_awaddr  = addr_q;
  assign o_axi_awvalid = (state_q == AW_W) && !aw_done_q;
  assign o_axi_awid    = AXI_ID;
  assign o_axi_awlen   = 8'd0;
  assign o_axi_awsize  = {1'b0, size_q};
  assign o_axi_awburst = 2'b01;
  assign o_axi_wdata   = wdata_q << {off, 3'b000};
  assign o_axi_wstrb   = strb_base << off;
  assign o_axi_wvalid  = (state_q == AW_W) && !w_done_q;
  assign o_axi_wlast   = 1'b1;
  assign o_axi_bready  = (state_q == B);

  assign o_dbg_state   = state_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, i_axi_rlast, i_axi_rid, i_axi_bid, i_axi_rresp[0], i_axi_bresp[0]};

endmodule

// File: tb/tb_axi_lsu_v2.sv
// Bench for axi_lsu_v2: directed and random loads/stores against a scoreboard of
// expected responses, plus one 64-bit instance for the doubleword path.
module tb_axi_lsu_v2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic i_reset;

  // ---------------- 32-bit DUT signals ----------------
  logic i_valid, o_ready, i_ren, i_wen, i_unsigned, o_valid, i_ready, o_fault, o_misalign;
  logic [31:0] i_addr, i_wdata, o_rdata;
  logic [1:0]  i_size;
  logic [4:0]  i_rd, o_rd;
  logic [31:0] o_axi_araddr, o_axi_awaddr, i_axi_rdata, o_axi_wdata;
  logic o_axi_arvalid, i_axi_arready, i_axi_rvalid, i_axi_rlast, o_axi_rready;
  logic o_axi_awvalid, i_axi_awready, o_axi_wvalid, i_axi_wready, o_axi_wlast;
  logic i_axi_bvalid, o_axi_bready;
  logic [3:0]  o_axi_arid, o_axi_awid, i_axi_rid, i_axi_bid, o_axi_wstrb;
  logic [7:0]  o_axi_arlen, o_axi_awlen;
  logic [2:0]  o_axi_arsize, o_axi_awsize, o_dbg_state;
  logic [1:0]  o_axi_arburst, o_axi_awburst, i_axi_rresp, i_axi_bresp;

  axi_lsu_v2 #(.DATA_W(32), .AXI_ID(4'h1)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_valid(i_valid), .o_ready(o_ready), .i_ren(i_ren), .i_wen(i_wen),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_size(i_size), .i_unsigned(i_unsigned), .i_rd(i_rd),
    .o_valid(o_valid), .i_ready(i_ready), .o_rdata(o_rdata), .o_rd(o_rd),
    .o_fault(o_fault), .o_misalign(o_misalign),
    .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
    .o_axi_arid(o_axi_arid), .o_axi_arlen(o_axi_arlen), .o_axi_arsize(o_axi_arsize),
    .o_axi_arburst(o_axi_arburst),
    .i_axi_rdata(i_axi_rdata), .i_axi_rvalid(i_axi_rvalid), .i_axi_rresp(i_axi_rresp),
    .i_axi_rlast(i_axi_rlast), .i_axi_rid(i_axi_rid), .o_axi_rready(o_axi_rready),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
    .o_axi_awid(o_axi_awid), .o_axi_awlen(o_axi_awlen), .o_axi_awsize(o_axi_awsize),
    .o_axi_awburst(o_axi_awburst), .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb),
    .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready), .o_axi_wlast(o_axi_wlast),
    .i_axi_bvalid(i_axi_bvalid), .i_axi_bresp(i_axi_bresp), .i_axi_bid(i_axi_bid),
    .o_axi_bready(o_axi_bready), .o_dbg_state(o_dbg_state)
  );

  // ---------------- 64-bit DUT signals ----------------
  logic v64, rdy64, ren64, wen64, uns64, ov64, ir64, flt64, mis64;
  logic [31:0] addr64, araddr64, awaddr64;
  logic [63:0] wd64, rdata64, axrdata64, axwdata64;
  logic [1:0]  size64, arburst64, awburst64, rresp64, bresp64;
  logic [4:0]  rd64, ord64;
  logic arvalid64, arready64, rvalid64, rready64, awvalid64, awready64, wvalid64, wready64;
  logic wlast64, bvalid64, bready64;
  logic [3:0]  arid64, awid64;
  logic [7:0]  arlen64, awlen64, wstrb64;
  logic [2:0]  arsize64, awsize64, dbg64;

  axi_lsu_v2 #(.DATA_W(64), .AXI_ID(4'h1)) dut64 (
    .i_clock(clk), .i_reset(i_reset),
    .i_valid(v64), .o_ready(rdy64), .i_ren(ren64), .i_wen(wen64),
    .i_addr(addr64), .i_wdata(wd64), .i_size(size64), .i_unsigned(uns64), .i_rd(rd64),
    .o_valid(ov64), .i_ready(ir64), .o_rdata(rdata64), .o_rd(ord64),
    .o_fault(flt64), .o_misalign(mis64),
    .o_axi_araddr(araddr64), .o_axi_arvalid(arvalid64), .i_axi_arready(arready64),
    .o_axi_arid(arid64), .o_axi_arlen(arlen64), .o_axi_arsize(arsize64),
    .o_axi_arburst(arburst64),
    .i_axi_rdata(axrdata64), .i_axi_rvalid(rvalid64), .i_axi_rresp(rresp64),
    .i_axi_rlast(1'b1), .i_axi_rid(4'h1), .o_axi_rready(rready64),
    .o_axi_awaddr(awaddr64), .o_axi_awvalid(awvalid64), .i_axi_awready(awready64),
    .o_axi_awid(awid64), .o_axi_awlen(awlen64), .o_axi_awsize(awsize64),
    .o_axi_awburst(awburst64), .o_axi_wdata(axwdata64), .o_axi_wstrb(wstrb64),
    .o_axi_wvalid(wvalid64), .i_axi_wready(wready64), .o_axi_wlast(wlast64),
    .i_axi_bvalid(bvalid64), .i_axi_bresp(bresp64), .i_axi_bid(4'h1),
    .o_axi_bready(bready64), .o_dbg_state(dbg64)
  );

  // ---------------- scoreboard ----------------
  localparam int EW = 39;  // {fault, misalign, rd[4:0], rdata[31:0]}
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] model_load(logic [31:0] raw, logic [31:0] addr,
                                             logic [1:0] sz, logic uns);
    int nb = 1 << sz;
    int off = int'(addr[1:0]);
    logic [31:0] r = '0;
    for (int b = 0; b < nb; b++) r[8*b +: 8] = raw[8*(off+b) +: 8];
    for (int b = nb; b < 4; b++) r[8*b +: 8] = (!uns && r[8*nb-1]) ? 8'hFF : 8'h00;
    return r;
  endfunction

  function automatic logic [31:0] model_wdata(logic [31:0] wd, logic [31:0] addr, logic [1:0] sz);
    int nb = 1 << sz;
    int off = int'(addr[1:0]);
    logic [31:0] r = '0;
    for (int b = 0; b < nb; b++) r[8*(off+b) +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [3:0] model_strb(logic [31:0] addr, logic [1:0] sz);
    int nb = 1 << sz;
    int off = int'(addr[1:0]);
    logic [3:0] s = '0;
    for (int b = 0; b < nb; b++) s[off+b] = 1'b1;
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    i_valid = 0; i_ren = 0; i_wen = 0; i_addr = '0; i_wdata = '0; i_size = '0;
    i_unsigned = 0; i_rd = '0; i_ready = 0;
    i_axi_arready = 0; i_axi_rdata = '0; i_axi_rvalid = 0; i_axi_rresp = '0;
    i_axi_rlast = 1; i_axi_rid = 4'h1; i_axi_awready = 0; i_axi_wready = 0;
    i_axi_bvalid = 0; i_axi_bresp = '0; i_axi_bid = 4'h1;
    v64 = 0; ren64 = 0; wen64 = 0; addr64 = '0; wd64 = '0; size64 = '0; uns64 = 0;
    rd64 = '0; ir64 = 0; arready64 = 0; axrdata64 = '0; rvalid64 = 0; rresp64 = '0;
    awready64 = 0; wready64 = 0; bvalid64 = 0; bresp64 = '0;
  endtask

  task automatic issue(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                       input logic [4:0] rd, input logic [31:0] exp_rdata,
                       input logic exp_fault, input logic exp_mis, output int acc_cyc);
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin
      failures++; $display("FAIL issue_ready: o_ready=%b required 1", o_ready);
    end
    i_valid = 1; i_ren = ren; i_wen = wen; i_addr = addr; i_wdata = wd;
    i_size = sz; i_unsigned = uns; i_rd = rd;
    acc_cyc = cyc;
    exp_q.push_back({exp_fault, exp_mis, rd, exp_rdata});
    @(negedge clk);
    i_valid = 0; i_ren = 0; i_wen = 0; i_wdata = $urandom;
  endtask

  task automatic serve_load(input logic [31:0] exp_addr, input logic [2:0] exp_size,
                            input int ar_wait, input logic [31:0] data, input logic [1:0] resp);
    int n = 0;
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (o_axi_arvalid) begin
        checks++;
        if (o_axi_araddr !== exp_addr || o_axi_arsize !== exp_size || o_axi_arlen !== 8'd0 ||
            o_axi_arburst !== 2'b01 || o_axi_arid !== 4'h1) begin
          failures++;
          $display("FAIL ar_fields: addr=%h size=%0d len=%0d burst=%b id=%h required addr=%h size=%0d len=0 burst=01 id=1",
                   o_axi_araddr, o_axi_arsize, o_axi_arlen, o_axi_arburst, o_axi_arid, exp_addr, exp_size);
        end
        if (n >= ar_wait) begin
          i_axi_arready = 1; done = 1;
        end else begin
          n++;
          // stray R beat while still in address phase must be ignored
          i_axi_rvalid = 1; i_axi_rdata = 32'hDEAD_BEEF; i_axi_rresp = 2'b10;
        end
      end
      @(negedge clk);
      i_axi_arready = 0; i_axi_rvalid = 0;
    end
    checks++;
    if (!done) begin failures++; $display("FAIL ar_timeout: arvalid=0 required 1"); return; end
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (o_axi_rready) begin
        i_axi_rvalid = 1; i_axi_rdata = data; i_axi_rresp = resp; done = 1;
      end
      @(negedge clk);
      i_axi_rvalid = 0;
    end
    checks++;
    if (!done) begin failures++; $display("FAIL r_timeout: rready=0 required 1"); end
  endtask

  task automatic serve_store(input logic [31:0] exp_addr, input logic [2:0] exp_size,
                             input int aw_wait, input int w_wait, input logic [31:0] exp_wd,
                             input logic [3:0] exp_strb, input logic [1:0] bresp);
    bit aw_done = 0, w_done = 0, done = 0;
    logic [31:0] bmask = '0;
    for (int b = 0; b < 4; b++) if (exp_strb[b]) bmask[8*b +: 8] = 8'hFF;
    for (int i = 0; i < 30 && !done; i++) begin
      if (o_axi_bready) begin
        checks++;
        if (!(aw_done && w_done)) begin
          failures++; $display("FAIL b_early: aw_done=%b w_done=%b required 1 1", aw_done, w_done);
        end
        i_axi_bvalid = 1; i_axi_bresp = bresp; done = 1;
      end else begin
        checks++;
        if ((aw_done && o_axi_awvalid) || (w_done && o_axi_wvalid)) begin
          failures++;
          $display("FAIL valid_after_hs: awvalid=%b wvalid=%b required 0 after handshake",
                   o_axi_awvalid, o_axi_wvalid);
        end
        if (o_axi_awvalid) begin
          checks++;
          if (o_axi_awaddr !== exp_addr || o_axi_awsize !== exp_size || o_axi_awlen !== 8'd0 ||
              o_axi_awburst !== 2'b01 || o_axi_awid !== 4'h1) begin
            failures++;
            $display("FAIL aw_fields: addr=%h size=%0d len=%0d burst=%b required addr=%h size=%0d len=0 burst=01",
                     o_axi_awaddr, o_axi_awsize, o_axi_awlen, o_axi_awburst, exp_addr, exp_size);
          end
        end
        if (o_axi_wvalid) begin
          checks++;
          if ((o_axi_wdata & bmask) !== (exp_wd & bmask) || o_axi_wstrb !== exp_strb ||
              o_axi_wlast !== 1'b1) begin
            failures++;
            $display("FAIL w_fields: wdata=%h wstrb=%b wlast=%b required wdata=%h wstrb=%b wlast=1",
                     o_axi_wdata & bmask, o_axi_wstrb, o_axi_wlast, exp_wd & bmask, exp_strb);
          end
        end
        i_axi_awready = (i >= aw_wait);
        i_axi_wready  = (i >= w_wait);
        if (o_axi_awvalid && i_axi_awready) aw_done = 1;
        if (o_axi_wvalid && i_axi_wready) w_done = 1;
        // stray B response outside B phase must be ignored
        i_axi_bvalid = 1; i_axi_bresp = 2'b10;
      end
      @(negedge clk);
      i_axi_awready = 0; i_axi_wready = 0; i_axi_bvalid = 0;
    end
    checks++;
    if (!done) begin failures++; $display("FAIL b_timeout: bready=0 required 1"); end
  endtask

  task automatic get_resp(input int hold, input int acc_cyc, input int exp_lat);
    logic [EW-1:0] exp, snap, got;
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (o_valid) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL resp_timeout: o_valid=0 required 1");
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_lat > 0) begin
      checks++;
      if (cyc - acc_cyc != exp_lat) begin
        failures++; $display("FAIL latency: got %0d cycles required %0d", cyc - acc_cyc, exp_lat);
      end
    end
    snap = {o_fault, o_misalign, o_rd, o_rdata};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || {o_fault, o_misalign, o_rd, o_rdata} !== snap) begin
        failures++;
        $display("FAIL hold_stable: valid=%b ready=%b out=%h required valid=1 ready=0 out=%h",
                 o_valid, o_ready, {o_fault, o_misalign, o_rd, o_rdata}, snap);
      end
    end
    got = {o_fault, o_misalign, o_rd, o_rdata};
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL sb_empty: response %h with no expectation", got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL resp: fault=%b mis=%b rd=%0d rdata=%h required fault=%b mis=%b rd=%0d rdata=%h",
                 got[38], got[37], got[36:32], got[31:0], exp[38], exp[37], exp[36:32], exp[31:0]);
      end
    end
    i_ready = 1;
    @(negedge clk);
    i_ready = 0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      failures++; $display("FAIL back_idle: valid=%b ready=%b required 0 1", o_valid, o_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_reset = 1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (o_ready !== 1 || o_valid !== 0 || o_axi_arvalid !== 0 || o_axi_rready !== 0 ||
        o_axi_awvalid !== 0 || o_axi_wvalid !== 0 || o_axi_bready !== 0 || o_fault !== 0 ||
        o_misalign !== 0 || o_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: ready=%b valid=%b arv=%b rr=%b awv=%b wv=%b br=%b flt=%b mis=%b rdata=%h required 1 0 0 0 0 0 0 0 0 0",
               o_ready, o_valid, o_axi_arvalid, o_axi_rready, o_axi_awvalid, o_axi_wvalid,
               o_axi_bready, o_fault, o_misalign, o_rdata);
    end
    i_reset = 0;
  endtask

  task automatic test_loads();
    int acc;
    // lb, sign extension from the top byte lane
    issue(1, 0, 32'h8000_0003, '0, 2'd0, 0, 5'd5, 32'hFFFF_FF80, 0, 0, acc);
    serve_load(32'h8000_0003, 3'd0, 0, 32'h80FF_FFFF, 2'b00);
    get_resp(0, acc, 3);
    // lbu with AR wait and stray R beats
    issue(1, 0, 32'h0000_1001, '0, 2'd0, 1, 5'd6, 32'h0000_0056, 0, 0, acc);
    serve_load(32'h0000_1001, 3'd0, 2, 32'h1234_5678, 2'b00);
    get_resp(0, acc, -1);
    // lh, upper half, negative
    issue(1, 0, 32'h0000_2002, '0, 2'd1, 0, 5'd7, 32'hFFFF_8001, 0, 0, acc);
    serve_load(32'h0000_2002, 3'd1, 1, 32'h8001_0000, 2'b00);
    get_resp(0, acc, -1);
    // lw with slave error
    issue(1, 0, 32'h0000_3000, '0, 2'd2, 0, 5'd8, 32'hCAFE_F00D, 1, 0, acc);
    serve_load(32'h0000_3000, 3'd2, 0, 32'hCAFE_F00D, 2'b10);
    get_resp(0, acc, 3);
  endtask

  task automatic test_stores();
    int acc;
    // sh to upper half, AW accepted two cycles before W
    issue(0, 1, 32'h8000_0002, 32'h0000_BEEF, 2'd1, 0, 5'd9, 32'h0, 0, 0, acc);
    serve_store(32'h8000_0002, 3'd1, 0, 2, 32'hBEEF_0000, 4'b1100, 2'b00);
    get_resp(0, acc, -1);
    // sw, W before AW, slave error
    issue(0, 1, 32'h0000_0010, 32'hCAFE_F00D, 2'd2, 0, 5'd10, 32'h0, 1, 0, acc);
    serve_store(32'h0000_0010, 3'd2, 2, 0, 32'hCAFE_F00D, 4'b1111, 2'b10);
    get_resp(0, acc, -1);
    // sb, both channels complete together; ren&&wen treated as store
    issue(1, 1, 32'h0000_0021, 32'h0000_00A5, 2'd0, 0, 5'd11, 32'h0, 0, 0, acc);
    serve_store(32'h0000_0021, 3'd0, 0, 0, 32'h0000_A500, 4'b0010, 2'b00);
    get_resp(0, acc, -1);
  endtask

  task automatic test_misalign();
    int acc;
    logic [31:0] addrs [3] = '{32'h8000_0002, 32'h0000_0008, 32'h0000_0101};
    logic [1:0]  sizes [3] = '{2'd2, 2'd3, 2'd1};
    logic        stores[3] = '{1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) begin
      issue(!stores[t], stores[t], addrs[t], 32'h1111_2222, sizes[t], 0, 5'(12 + t),
            32'h0, 0, 1, acc);
      checks++;
      if (o_axi_arvalid !== 0 || o_axi_awvalid !== 0 || o_axi_wvalid !== 0) begin
        failures++;
        $display("FAIL misalign_nobus: arv=%b awv=%b wv=%b required 0 0 0",
                 o_axi_arvalid, o_axi_awvalid, o_axi_wvalid);
      end
      get_resp(0, acc, 1);
    end
  endtask

  task automatic test_passthrough();
    int acc;
    issue(0, 0, 32'h0000_0003, 32'h5555_5555, 2'd2, 0, 5'd21, 32'h0, 0, 0, acc);
    get_resp(3, acc, 1);
  endtask

  task automatic test_reset_in_ar();
    int acc;
    issue(1, 0, 32'h0000_4000, '0, 2'd2, 0, 5'd22, 32'h0, 0, 0, acc);
    checks++;
    if (o_axi_arvalid !== 1) begin
      failures++; $display("FAIL ar_before_reset: arvalid=%b required 1", o_axi_arvalid);
    end
    i_reset = 1;
    @(negedge clk);
    checks++;
    if (o_axi_arvalid !== 0 || o_ready !== 1 || o_valid !== 0) begin
      failures++;
      $display("FAIL reset_in_ar: arvalid=%b ready=%b valid=%b required 0 1 0",
               o_axi_arvalid, o_ready, o_valid);
    end
    i_reset = 0;
    void'(exp_q.pop_back());
  endtask

  task automatic test_back_to_back();
    int acc;
    for (int it = 0; it < 10; it++) begin
      logic [1:0]  sz  = 2'($urandom_range(0, 2));
      logic [31:0] a   = $urandom & ~((32'd1 << sz) - 32'd1);
      logic [31:0] d   = $urandom;
      logic        uns = 1'($urandom_range(0, 1));
      logic [1:0]  rsp = $urandom_range(0, 1) ? 2'b10 : 2'b00;
      logic [4:0]  rd  = 5'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        issue(1, 0, a, '0, sz, uns, rd, model_load(d, a, sz, uns), rsp[1], 0, acc);
        serve_load(a, {1'b0, sz}, $urandom_range(0, 2), d, rsp);
      end else begin
        issue(0, 1, a, d, sz, 0, rd, 32'h0, rsp[1], 0, acc);
        serve_store(a, {1'b0, sz}, $urandom_range(0, 2), $urandom_range(0, 2),
                    model_wdata(d, a, sz), model_strb(a, sz), rsp);
      end
      get_resp($urandom_range(0, 1), acc, -1);
    end
  endtask

  task automatic test_ld64();
    bit done = 0;
    @(negedge clk);
    v64 = 1; ren64 = 1; addr64 = 32'h8000_0008; size64 = 2'd3; rd64 = 5'd3;
    @(negedge clk);
    v64 = 0; ren64 = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (arvalid64) begin
        checks++;
        if (arsize64 !== 3'd3 || araddr64 !== 32'h8000_0008) begin
          failures++; $display("FAIL ld64_ar: size=%0d addr=%h required 3 80000008", arsize64, araddr64);
        end
        arready64 = 1; done = 1;
      end
      @(negedge clk);
      arready64 = 0;
    end
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rready64) begin
        rvalid64 = 1; axrdata64 = 64'h0123_4567_89AB_CDEF; rresp64 = 2'b10; done = 1;
      end
      @(negedge clk);
      rvalid64 = 0;
    end
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (ov64) done = 1;
      else @(negedge clk);
    end
    checks++;
    if (!done || rdata64 !== 64'h0123_4567_89AB_CDEF || flt64 !== 1 || mis64 !== 0 || ord64 !== 5'd3) begin
      failures++;
      $display("FAIL ld64_resp: valid=%b rdata=%h fault=%b mis=%b rd=%0d required 1 0123456789abcdef 1 0 3",
               ov64, rdata64, flt64, mis64, ord64);
    end
    ir64 = 1;
    @(negedge clk);
    ir64 = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    i_reset = 1;
    test_reset();
    test_loads();
    test_stores();
    test_misalign();
    test_passthrough();
    test_reset_in_ar();
    test_back_to_back();
    test_ld64();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover: %0d entries required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
